id_operand_stage: RTL and testbench
===================================

# id_operand_stage

Parametrised IF/ID pipeline register plus operand-fetch unit for the five-stage MIPS core. It latches the fetched PC and holds the synchronous-SRAM instruction across stalls. It reads rs/rt from an internal register file and resolves operands through a configurable number of prioritised forwarding sources. It raises a stall request when a matching source's data is not ready yet (load-use); the downstream decoder consumes its outputs.

## Interface
Parameters:
- XLEN, 32, datapath and PC width
- NREG, 32, architectural register count; RAW = $clog2(NREG)
- NFWD, 2, forwarding sources; index 0 = youngest (EX/MEM), highest priority

Ports:
- clk  in  1  clock
- rst  in  1  reset: rst, synchronous, active-high; clock clk
- stall_id  in  1  hold this stage's register
- stall_ex  in  1  hold next stage; stall_id && !stall_ex inserts bubble
- flush  in  1  squash instruction in stage (taken branch)
- if_valid  in  1  fetch slot valid
- if_pc  in  XLEN  fetch PC
- inst_sram_rdata  in  32  SRAM data, one cycle after address
- wb_we  in  1  regfile write enable
- wb_waddr  in  RAW  write address
- wb_wdata  in  XLEN  write data
- fwd_we  in  NFWD  source i writes a register
- fwd_waddr  in  NFWD*RAW  destination of source i, packed, i at lowest slice
- fwd_wdata  in  NFWD*XLEN  result of source i
- fwd_ready  in  NFWD  source i data valid (0 = load not yet returned)
- id_valid  out  1  stage holds a live instruction
- id_pc  out  XLEN  PC of that instruction
- id_inst  out  32  instruction word
- rs_data  out  XLEN  resolved operand for inst[25:21]
- rt_data  out  XLEN  resolved operand for inst[20:16]
- stallreq  out  1  operand hazard, request stall

## Operation
- Stage register update priority: rst > flush > bubble (stall_id && !stall_ex) > load (!stall_id) > hold.
  - rst, flush and bubble set valid=0, pc=0.
  - Load captures if_valid, if_pc.
- Instruction hold: SRAM data corresponds to the stage content only in the first cycle after a load. On that cycle, if stall_id=1, capture inst_sram_rdata into inst_r and set held=1.
  - id_inst = held ? inst_r : inst_sram_rdata.
  - held clears on load, bubble, flush and rst.
  - id_inst = 0 when !id_valid.
- Register file: NREG x XLEN, 2 read / 1 write, all entries cleared on rst.
  - Writes to register 0 are ignored; register 0 reads 0.
  - Write-through: a read of wb_waddr while wb_we=1 returns wb_wdata.
- Operand resolution, per operand, address a:
  - a==0 → 0, no hazard.
  - Otherwise the lowest i with fwd_we[i] && fwd_waddr[i]==a decides the result: data is fwd_wdata[i] if fwd_ready[i], else hazard.
  - No match → write-through regfile value.
  - A not-ready younger source is never bypassed by an older ready source.
- stallreq = id_valid && (hazard_rs || hazard_rt).
  - Both fields are checked regardless of format (a spurious stall on an unused rt is accepted).
  - The stall controller is expected to assert stall_id and stall_ex=0 in response, which bubbles EX.

## Timing
- Reset values: id_valid=0, id_pc=0, id_inst=0, held=0, rs_data=rt_data=0, stallreq=0.
- Latency: if_* to id_* is 1 cycle. Operands and stallreq are combinational from stage state, inst and fwd/wb inputs in the same cycle.
- flush together with stall_id: flush wins and the slot is emptied.
- stall_id held for N cycles: id_pc and id_inst stay constant for all N cycles, even though inst_sram_rdata changes.
- rst mid-stall discards held instruction and regfile contents.

## Structure
- Shared package id_pkg:
  - XLEN default
  - field LSBs RS_LSB=21, RT_LSB=16
  - REG_ZERO
  - packed-slice helper macros for fwd_* buses
- One sub-module, id_regfile: 2R1W, write-through, synchronous clear. Forwarding mux and stage register stay in the top.

## Test plan
- Load and hold: load pc=0x100 with inst 0x012A4020, then stall_id=1 for 3 cycles while SRAM data changes → id_inst stays 0x012A4020 and id_pc stays 0x100 throughout.
- Forward priority: rs=9, fwd0 (we=1, addr 9, 0xAAAA, ready 1) and fwd1 (addr 9, 0xBBBB) → rs_data=0xAAAA. Drop fwd0.we → 0xBBBB.
- Load-use: fwd0 (addr 10, ready 0), rt=10, fwd1 ready with addr 10 → stallreq=1. Raise ready to 1 → stallreq=0, rt_data=fwd0 data.
- Zero register and write-through: fwd0 addr 0 with 0x1234 and rs=0 → rs_data=0, stallreq=0. wb_we=1 to reg 5 with 0xDEAD, rt=5, no fwd match → rt_data=0xDEAD in the same cycle.
- Flush/bubble: flush together with stall_id → id_valid=0 next cycle. stall_id=1, stall_ex=0 → id_valid=0 and held cleared.
- Reset mid-operation: rst asserted during a stall → all outputs 0 next cycle, and a read of reg 5 returns 0.

Source files
------------

// File: rtl/id_pkg.sv
// Shared constants for the ID/operand-fetch slice of the five-stage MIPS core,
// plus slice helpers for the packed per-source forwarding buses.
`ifndef ID_PKG_MACROS
`define ID_PKG_MACROS
`define ID_SLICE(BUS_, IDX_, W_) BUS_[(IDX_)*(W_) +: (W_)]
`endif

package id_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int NREG_DEFAULT = 32;
  localparam int NFWD_DEFAULT = 2;
  localparam int RS_LSB       = 21;
  localparam int RT_LSB       = 16;
  localparam int REG_ZERO     = 0;
endpackage

// File: rtl/id_operand_stage_if.sv
// Fetch-side, writeback/forwarding and decoder-side signals of the operand stage.
interface id_operand_stage_if
  import id_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREG = NREG_DEFAULT,
  parameter int NFWD = NFWD_DEFAULT
);
  localparam int RAW = $clog2(NREG);

  logic                 stall_id;
  logic                 stall_ex;
  logic                 flush;
  logic                 if_valid;
  logic [XLEN-1:0]      if_pc;
  logic [31:0]          inst_sram_rdata;
  logic                 wb_we;
  logic [RAW-1:0]       wb_waddr;
  logic [XLEN-1:0]      wb_wdata;
  logic [NFWD-1:0]      fwd_we;
  logic [NFWD*RAW-1:0]  fwd_waddr;
  logic [NFWD*XLEN-1:0] fwd_wdata;
  logic [NFWD-1:0]      fwd_ready;
  logic                 id_valid;
  logic [XLEN-1:0]      id_pc;
  logic [31:0]          id_inst;
  logic [XLEN-1:0]      rs_data;
  logic [XLEN-1:0]      rt_data;
  logic                 stallreq;

  modport master (
    output stall_id, stall_ex, flush, if_valid, if_pc, inst_sram_rdata,
           wb_we, wb_waddr, wb_wdata, fwd_we, fwd_waddr, fwd_wdata, fwd_ready,
    input  id_valid, id_pc, id_inst, rs_data, rt_data, stallreq
  );

  modport slave (
    input  stall_id, stall_ex, flush, if_valid, if_pc, inst_sram_rdata,
           wb_we, wb_waddr, wb_wdata, fwd_we, fwd_waddr, fwd_wdata, fwd_ready,
    output id_valid, id_pc, id_inst, rs_data, rt_data, stallreq
  );
endinterface

// File: rtl/id_regfile.sv
// 2-read/1-write register file with write-through reads and hard-wired zero register.
module id_regfile
  import id_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREG = NREG_DEFAULT,
  parameter int RAW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [RAW-1:0]  i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [RAW-1:0]  i_raddr_a,
  input  logic [RAW-1:0]  i_raddr_b,
  output logic [XLEN-1:0] o_rdata_a,
  output logic [XLEN-1:0] o_rdata_b
);
  logic [XLEN-1:0] r_mem [NREG];

  // NOTE: the whole array is cleared on reset because a reset must discard
  // architectural state; this keeps it in flops rather than an SRAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) r_mem[k] <= '0;
    end else if (i_we && i_waddr != RAW'(REG_ZERO)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == RAW'(REG_ZERO))          ? '0      :
                     (i_we && i_waddr == i_raddr_a)          ? i_wdata : r_mem[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == RAW'(REG_ZERO))          ? '0      :
                     (i_we && i_waddr == i_raddr_b)          ? i_wdata : r_mem[i_raddr_b];
endmodule

// File: rtl/id_operand_stage.sv
// IF/ID pipeline register with SRAM instruction hold, register read and
// prioritised operand forwarding with load-use stall request.
module id_operand_stage
  import id_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREG = NREG_DEFAULT,
  parameter int NFWD = NFWD_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  id_operand_stage_if.slave bus
);
  localparam int RAW = $clog2(NREG);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_inst;
  logic            r_held;
  logic            r_fresh;   // first cycle after a load: SRAM data matches the slot
  logic            w_bubble;
  logic [31:0]     w_inst;
  logic [RAW-1:0]  w_rs_addr;
  logic [RAW-1:0]  w_rt_addr;
  logic [XLEN-1:0] w_rf_rs;
  logic [XLEN-1:0] w_rf_rt;
  logic [XLEN-1:0] w_rs_data;
  logic [XLEN-1:0] w_rt_data;
  logic            w_rs_haz;
  logic            w_rt_haz;

  assign w_bubble = bus.stall_id && !bus.stall_ex;

  always_ff @(posedge clk) begin
    if (rst || bus.flush || w_bubble) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_held  <= 1'b0;
      r_fresh <= 1'b0;
    end else if (!bus.stall_id) begin
      r_valid <= bus.if_valid;
      r_pc    <= bus.if_pc;
      r_held  <= 1'b0;
      r_fresh <= 1'b1;
    end else begin
      r_fresh <= 1'b0;
      if (r_fresh) r_held <= 1'b1;
    end
  end

  // Data-only capture register: r_held qualifies it, so it needs no reset.
  always_ff @(posedge clk) begin
    if (!rst && !bus.flush && bus.stall_id && bus.stall_ex && r_fresh)
      r_inst <= bus.inst_sram_rdata;
  end

  assign w_inst    = !r_valid ? '0 : (r_held ? r_inst : bus.inst_sram_rdata);
  assign w_rs_addr = w_inst[RS_LSB +: RAW];
  assign w_rt_addr = w_inst[RT_LSB +: RAW];

  id_regfile #(.XLEN(XLEN), .NREG(NREG), .RAW(RAW)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_we      (bus.wb_we),
    .i_waddr   (bus.wb_waddr),
    .i_wdata   (bus.wb_wdata),
    .i_raddr_a (w_rs_addr),
    .i_raddr_b (w_rt_addr),
    .o_rdata_a (w_rf_rs),
    .o_rdata_b (w_rf_rt)
  );

  // Oldest source first so the youngest matching source overwrites the result;
  // a not-ready younger match therefore shadows any older ready one.
  // NOTE: combinational logic uses blocking assignments and sets every output
  // to a default first, so no path leaves a value unassigned and no latch forms.
  always_comb begin
    w_rs_data = w_rf_rs;
    w_rt_data = w_rf_rt;
    w_rs_haz  = 1'b0;
    w_rt_haz  = 1'b0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (bus.fwd_we[i] && `ID_SLICE(bus.fwd_waddr, i, RAW) == w_rs_addr) begin
        w_rs_data = bus.fwd_ready[i] ? `ID_SLICE(bus.fwd_wdata, i, XLEN) : '0;
        w_rs_haz  = !bus.fwd_ready[i];
      end
      if (bus.fwd_we[i] && `ID_SLICE(bus.fwd_waddr, i, RAW) == w_rt_addr) begin
        w_rt_data = bus.fwd_ready[i] ? `ID_SLICE(bus.fwd_wdata, i, XLEN) : '0;
        w_rt_haz  = !bus.fwd_ready[i];
      end
    end
    if (w_rs_addr == RAW'(REG_ZERO)) begin
      w_rs_data = '0;
      w_rs_haz  = 1'b0;
    end
    if (w_rt_addr == RAW'(REG_ZERO)) begin
      w_rt_data = '0;
      w_rt_haz  = 1'b0;
    end
  end

  assign bus.id_valid = r_valid;
  assign bus.id_pc    = r_pc;
  assign bus.id_inst  = w_inst;
  assign bus.rs_data  = w_rs_data;
  assign bus.rt_data  = w_rt_data;
  assign bus.stallreq = r_valid && (w_rs_haz || w_rt_haz);
endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: operand table plus stall/flush/reset sequences.
module tb_id_operand_stage;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  id_operand_stage_if #(.XLEN(32), .NREG(32), .NFWD(2)) bus ();

  id_operand_stage #(.XLEN(32), .NREG(32), .NFWD(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [1:0]  we;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  rdy;
    logic [1:0]  chk;     // bit0: compare rs_data, bit1: compare rt_data
    logic [31:0] exp_rs;
    logic [31:0] exp_rt;
    logic        exp_stall;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic [31:0] mk_inst(input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, 16'h0000};
  endfunction

  initial begin
    total = 0;
    bad   = 0;

    //            name         rs     rt     we     a0     a1     d0            d1            rdy    chk    exp_rs        exp_rt        st
    vecs[0] = '{"prio_fwd0", 5'd9,  5'd3,  2'b11, 5'd9,  5'd9,  32'h0000AAAA, 32'h0000BBBB, 2'b11, 2'b11, 32'h0000AAAA, 32'h00001003, 1'b0};
    vecs[1] = '{"prio_fwd1", 5'd9,  5'd3,  2'b10, 5'd9,  5'd9,  32'h0000AAAA, 32'h0000BBBB, 2'b11, 2'b11, 32'h0000BBBB, 32'h00001003, 1'b0};
    vecs[2] = '{"load_use",  5'd1,  5'd10, 2'b11, 5'd10, 5'd10, 32'h00001111, 32'h00002222, 2'b10, 2'b01, 32'h00001001, 32'h0,        1'b1};
    vecs[3] = '{"load_done", 5'd1,  5'd10, 2'b11, 5'd10, 5'd10, 32'h00001111, 32'h00002222, 2'b11, 2'b11, 32'h00001001, 32'h00001111, 1'b0};
    vecs[4] = '{"zero_fwd",  5'd0,  5'd0,  2'b01, 5'd0,  5'd0,  32'h00001234, 32'h0,        2'b01, 2'b11, 32'h0,        32'h0,        1'b0};
    vecs[5] = '{"zero_nrdy", 5'd0,  5'd31, 2'b01, 5'd0,  5'd0,  32'h00001234, 32'h0,        2'b00, 2'b11, 32'h0,        32'h0000101F, 1'b0};
    vecs[6] = '{"fwd1_nrdy", 5'd7,  5'd7,  2'b10, 5'd0,  5'd7,  32'h0,        32'h00007777, 2'b01, 2'b00, 32'h0,        32'h0,        1'b1};
    vecs[7] = '{"old_nrdy",  5'd12, 5'd2,  2'b11, 5'd12, 5'd12, 32'h0000C0DE, 32'h0000DEAD, 2'b01, 2'b11, 32'h0000C0DE, 32'h00001002, 1'b0};
    vecs[8] = '{"two_srcs",  5'd4,  5'd6,  2'b11, 5'd4,  5'd6,  32'h00000044, 32'h00000066, 2'b11, 2'b11, 32'h00000044, 32'h00000066, 1'b0};
    vecs[9] = '{"we_off",    5'd4,  5'd6,  2'b00, 5'd4,  5'd6,  32'h00000044, 32'h00000066, 2'b00, 2'b11, 32'h00001004, 32'h00001006, 1'b0};

    rst                 = 1'b1;
    bus.stall_id        = 1'b0;
    bus.stall_ex        = 1'b0;
    bus.flush           = 1'b0;
    bus.if_valid        = 1'b0;
    bus.if_pc           = '0;
    bus.inst_sram_rdata = 32'hFFFFFFFF;
    bus.wb_we           = 1'b0;
    bus.wb_waddr        = '0;
    bus.wb_wdata        = '0;
    bus.fwd_we          = '0;
    bus.fwd_waddr       = '0;
    bus.fwd_wdata       = '0;
    bus.fwd_ready       = '0;
    tick();
    tick();
    settle();
    check("rst_valid", 32'(bus.id_valid), 32'h0);
    check("rst_pc",    bus.id_pc,         32'h0);
    check("rst_inst",  bus.id_inst,       32'h0);
    check("rst_rs",    bus.rs_data,       32'h0);
    check("rst_rt",    bus.rt_data,       32'h0);
    check("rst_stall", 32'(bus.stallreq), 32'h0);

    // Load pc 0x100 and hold it for three stalled cycles while SRAM data moves.
    rst          = 1'b0;
    bus.if_valid = 1'b1;
    bus.if_pc    = 32'h100;
    tick();
    bus.inst_sram_rdata = 32'h012A4020;
    settle();
    check("load_valid", 32'(bus.id_valid), 32'h1);
    check("load_pc",    bus.id_pc,         32'h100);
    check("load_inst",  bus.id_inst,       32'h012A4020);
    bus.stall_id = 1'b1;
    bus.stall_ex = 1'b1;
    bus.if_pc    = 32'h104;
    for (int k = 1; k <= 3; k++) begin
      tick();
      bus.inst_sram_rdata = 32'h11111111 * k;
      settle();
      check("hold_inst", bus.id_inst, 32'h012A4020);
      check("hold_pc",   bus.id_pc,   32'h100);
    end

    // Bubble: stall_id with stall_ex low empties the slot.
    bus.stall_ex = 1'b0;
    tick();
    settle();
    check("bubble_valid", 32'(bus.id_valid), 32'h0);
    check("bubble_pc",    bus.id_pc,         32'h0);
    check("bubble_inst",  bus.id_inst,       32'h0);

    bus.stall_id = 1'b0;
    bus.if_pc    = 32'h200;
    tick();
    bus.inst_sram_rdata = 32'h22222222;
    settle();
    check("reload_pc",   bus.id_pc,   32'h200);
    check("reload_inst", bus.id_inst, 32'h22222222);

    // Flush wins over a simultaneous stall.
    bus.stall_id = 1'b1;
    bus.stall_ex = 1'b1;
    bus.flush    = 1'b1;
    tick();
    bus.flush    = 1'b0;
    settle();
    check("flush_valid", 32'(bus.id_valid), 32'h0);
    check("flush_pc",    bus.id_pc,         32'h0);

    // Preload registers r = 0x1000 + r while the stage keeps loading.
    bus.stall_id = 1'b0;
    bus.stall_ex = 1'b0;
    bus.if_pc    = 32'h400;
    bus.wb_we    = 1'b1;
    for (int r = 1; r < 32; r++) begin
      bus.wb_waddr = 5'(r);
      bus.wb_wdata = 32'h1000 + r;
      tick();
    end
    bus.wb_we = 1'b0;

    for (int v = 0; v < 10; v++) begin
      tick();
      bus.inst_sram_rdata = mk_inst(vecs[v].rs, vecs[v].rt);
      bus.fwd_we          = vecs[v].we;
      bus.fwd_waddr       = {vecs[v].a1, vecs[v].a0};
      bus.fwd_wdata       = {vecs[v].d1, vecs[v].d0};
      bus.fwd_ready       = vecs[v].rdy;
      settle();
      if (vecs[v].chk[0]) check({vecs[v].name, "_rs"}, bus.rs_data, vecs[v].exp_rs);
      if (vecs[v].chk[1]) check({vecs[v].name, "_rt"}, bus.rt_data, vecs[v].exp_rt);
      check({vecs[v].name, "_stall"}, 32'(bus.stallreq), 32'(vecs[v].exp_stall));
    end
    bus.fwd_we = '0;

    // Write-through in the same cycle, then the stored value after the edge.
    tick();
    bus.inst_sram_rdata = mk_inst(5'd0, 5'd5);
    bus.wb_we           = 1'b1;
    bus.wb_waddr        = 5'd5;
    bus.wb_wdata        = 32'hDEAD;
    settle();
    check("wthru_rt", bus.rt_data, 32'hDEAD);
    tick();
    bus.wb_we = 1'b0;
    settle();
    check("stored_rt", bus.rt_data, 32'hDEAD);

    bus.inst_sram_rdata = mk_inst(5'd0, 5'd0);
    bus.wb_we           = 1'b1;
    bus.wb_waddr        = 5'd0;
    bus.wb_wdata        = 32'hFFFF;
    settle();
    check("r0_wthru", bus.rs_data, 32'h0);
    tick();
    bus.wb_we = 1'b0;

    // Reset during a stall drops the held instruction and the register file.
    bus.inst_sram_rdata = mk_inst(5'd5, 5'd5);
    bus.if_pc           = 32'h300;
    tick();
    bus.stall_id = 1'b1;
    bus.stall_ex = 1'b1;
    tick();
    bus.inst_sram_rdata = 32'h33333333;
    settle();
    check("prerst_rt", bus.rt_data, 32'hDEAD);
    rst = 1'b1;
    tick();
    settle();
    check("midrst_valid", 32'(bus.id_valid), 32'h0);
    check("midrst_pc",    bus.id_pc,         32'h0);
    check("midrst_inst",  bus.id_inst,       32'h0);
    check("midrst_rs",    bus.rs_data,       32'h0);
    check("midrst_rt",    bus.rt_data,       32'h0);
    check("midrst_stall", 32'(bus.stallreq), 32'h0);
    rst          = 1'b0;
    bus.stall_id = 1'b0;
    bus.stall_ex = 1'b0;
    bus.if_pc    = 32'h500;
    tick();
    bus.inst_sram_rdata = mk_inst(5'd0, 5'd5);
    settle();
    check("postrst_inst", bus.id_inst, mk_inst(5'd0, 5'd5));
    check("postrst_r5",   bus.rt_data, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
